// File: rtl/l1_cache_ctrl.sv
// Control FSM for a 256-line direct-mapped write-back L1 array.
// A hit responds two cycles after acceptance; misses add the L2 handshake cycles.
`timescale 1ns/1ps
module l1_cache_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req_valid,
   output logic             cpu_req_ready,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [63:0]      cpu_wdata,
   output logic             cpu_resp_valid,
   output logic [63:0]      cpu_rdata,
   output logic             cpu_resp_hit,
   output logic [31:0]      arr_addr,
   input  logic [23:0]      arr_tag_vd,
   input  logic [63:0]      arr_data,
   output logic [23:0]      arr_tag_upd,
   output logic             arr_fill_we,
   output logic [63:0]      arr_fill_data,
   output logic             arr_cpu_we,
   output logic [63:0]      arr_wdata,
   output logic             l2_req_valid,
   input  logic             l2_req_ready,
   output logic             l2_req_we,
   output logic [31:0]      l2_req_addr,
   output logic [63:0]      l2_req_wdata,
   input  logic             l2_resp_valid,
   input  logic [63:0]      l2_resp_data,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RESP
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state;
   logic        req_we;
   logic [21:0] req_tag;
   logic [7:0]  req_idx;
   logic        hit;
   logic        victim_dirty;

   assign req_tag      = arr_addr[31:10];
   assign req_idx      = arr_addr[9:2];
   assign hit          = arr_tag_vd[23] && (arr_tag_vd[21:0] == req_tag);
   assign victim_dirty = arr_tag_vd[23] && arr_tag_vd[22];

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         req_we         <= 1'b0;
         cpu_req_ready  <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_rdata      <= '0;
         cpu_resp_hit   <= 1'b0;
         arr_addr       <= '0;
         arr_tag_upd    <= '0;
         arr_fill_we    <= 1'b0;
         arr_fill_data  <= '0;
         arr_cpu_we     <= 1'b0;
         arr_wdata      <= '0;
         l2_req_valid   <= 1'b0;
         l2_req_we      <= 1'b0;
         l2_req_addr    <= '0;
         l2_req_wdata   <= '0;
         hit_cnt        <= '0;
         miss_cnt       <= '0;
      end else begin
         cpu_resp_valid <= 1'b0;
         arr_cpu_we     <= 1'b0;
         arr_fill_we    <= 1'b0;
         case (state)
            IDLE: begin
               cpu_req_ready <= 1'b1;
               if (cpu_req_valid && cpu_req_ready) begin
                  cpu_req_ready <= 1'b0;
                  arr_addr      <= cpu_addr;
                  req_we        <= cpu_we;
                  arr_wdata     <= cpu_wdata;
                  state         <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_ONE;
               end else begin
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_ONE;
               end
               if (!req_we && hit) begin
                  cpu_rdata      <= arr_data;
                  cpu_resp_hit   <= 1'b1;
                  cpu_resp_valid <= 1'b1;
                  state          <= RESP;
               end else if (req_we && (hit || !victim_dirty)) begin
                  arr_cpu_we     <= 1'b1;
                  arr_tag_upd    <= {2'b11, req_tag};
                  cpu_resp_hit   <= hit;
                  cpu_resp_valid <= 1'b1;
                  state          <= RESP;
               end else if (victim_dirty) begin
                  // victim tag travels in the writeback address
                  l2_req_valid <= 1'b1;
                  l2_req_we    <= 1'b1;
                  l2_req_addr  <= {arr_tag_vd[21:0], req_idx, 2'b00};
                  l2_req_wdata <= arr_data;
                  state        <= WB_REQ;
               end else begin
                  l2_req_valid <= 1'b1;
                  l2_req_we    <= 1'b0;
                  l2_req_addr  <= {req_tag, req_idx, 2'b00};
                  state        <= RF_REQ;
               end
            end
            WB_REQ: begin
               if (l2_req_ready) begin
                  l2_req_valid <= 1'b0;
                  state        <= WB_WAIT;
               end
            end
            WB_WAIT: begin
               if (l2_resp_valid) begin
                  if (req_we) begin
                     arr_cpu_we     <= 1'b1;
                     arr_tag_upd    <= {2'b11, req_tag};
                     cpu_resp_hit   <= 1'b0;
                     cpu_resp_valid <= 1'b1;
                     state          <= RESP;
                  end else begin
                     l2_req_valid <= 1'b1;
                     l2_req_we    <= 1'b0;
                     l2_req_addr  <= {req_tag, req_idx, 2'b00};
                     state        <= RF_REQ;
                  end
               end
            end
            RF_REQ: begin
               if (l2_req_ready) begin
                  l2_req_valid <= 1'b0;
                  state        <= RF_WAIT;
               end
            end
            RF_WAIT: begin
               if (l2_resp_valid) begin
                  arr_fill_we    <= 1'b1;
                  arr_fill_data  <= l2_resp_data;
                  arr_tag_upd    <= {2'b10, req_tag};
                  cpu_rdata      <= l2_resp_data;
                  cpu_resp_hit   <= 1'b0;
                  cpu_resp_valid <= 1'b1;
                  state          <= RESP;
               end
            end
            RESP: begin
               cpu_req_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Randomized scoreboard bench for l1_cache_ctrl with array and L2 models.
`timescale 1ns/1ps
module tb_l1_cache_ctrl;

   localparam int CNT_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req_valid, cpu_req_ready, cpu_we;
   logic [31:0]       cpu_addr;
   logic [63:0]       cpu_wdata;
   logic              cpu_resp_valid, cpu_resp_hit;
   logic [63:0]       cpu_rdata;
   logic [31:0]       arr_addr;
   logic [23:0]       arr_tag_vd, arr_tag_upd;
   logic [63:0]       arr_data, arr_fill_data, arr_wdata;
   logic              arr_fill_we, arr_cpu_we;
   logic              l2_req_valid, l2_req_ready, l2_req_we;
   logic [31:0]       l2_req_addr;
   logic [63:0]       l2_req_wdata;
   logic              l2_resp_valid;
   logic [63:0]       l2_resp_data;
   logic [CNT_W-1:0]  hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   l1_cache_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_resp_valid(cpu_resp_valid),
      .cpu_rdata(cpu_rdata), .cpu_resp_hit(cpu_resp_hit), .arr_addr(arr_addr),
      .arr_tag_vd(arr_tag_vd), .arr_data(arr_data), .arr_tag_upd(arr_tag_upd),
      .arr_fill_we(arr_fill_we), .arr_fill_data(arr_fill_data), .arr_cpu_we(arr_cpu_we),
      .arr_wdata(arr_wdata), .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
      .l2_req_we(l2_req_we), .l2_req_addr(l2_req_addr), .l2_req_wdata(l2_req_wdata),
      .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   typedef struct packed {
      logic        hit;
      logic [63:0] rdata;
      logic        chk_rd;
      logic        chk_lat;
      logic [31:0] acc;
      logic [31:0] hc;
      logic [31:0] mc;
   } resp_t;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [63:0] wdata;
   } l2_t;
   typedef struct packed {
      logic        fill;
      logic [7:0]  idx;
      logic [23:0] tag_upd;
      logic [63:0] data;
   } arr_t;

   resp_t exp_resp[$];
   l2_t   exp_l2[$];
   arr_t  exp_arr[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mem_init(input logic [31:0] a);
      return {a ^ 32'h5A5A_3C3C, ~a};
   endfunction

   // storage array seen by the DUT
   logic [23:0] tag_mem [256];
   logic [63:0] dat_mem [256];
   logic        arr_clear;
   assign arr_tag_vd = tag_mem[arr_addr[9:2]];
   assign arr_data   = dat_mem[arr_addr[9:2]];
   always @(posedge clk) begin
      if (arr_clear) begin
         for (int i = 0; i < 256; i++) begin
            tag_mem[i] <= '0;
            dat_mem[i] <= '0;
         end
      end else begin
         if (arr_cpu_we) begin
            tag_mem[arr_addr[9:2]] <= arr_tag_upd;
            dat_mem[arr_addr[9:2]] <= arr_wdata;
         end
         if (arr_fill_we) begin
            tag_mem[arr_addr[9:2]] <= arr_tag_upd;
            dat_mem[arr_addr[9:2]] <= arr_fill_data;
         end
      end
   end

   // reference cache model: per-line state plus backing memory
   logic        r_v [256];
   logic        r_d [256];
   logic [21:0] r_tag [256];
   logic [63:0] r_dat [256];
   logic [63:0] ref_mem [logic [29:0]];
   int unsigned r_hc, r_mc;

   task automatic ref_req(input logic we, input logic [31:0] addr, input logic [63:0] wd);
      logic [7:0]  idx;
      logic [21:0] tag;
      logic        hit;
      logic        lat;
      logic [63:0] rd;
      idx = addr[9:2];
      tag = addr[31:10];
      hit = r_v[idx] && (r_tag[idx] == tag);
      rd  = r_dat[idx];
      lat = 1'b1;
      if (hit) r_hc++; else r_mc++;
      if (!hit) begin
         if (r_v[idx] && r_d[idx]) begin
            exp_l2.push_back('{1'b1, {r_tag[idx], idx, 2'b00}, r_dat[idx]});
            ref_mem[{r_tag[idx], idx}] = r_dat[idx];
            lat = 1'b0;
         end
         if (!we) begin
            rd = ref_mem.exists({tag, idx}) ? ref_mem[{tag, idx}] : mem_init({tag, idx, 2'b00});
            exp_l2.push_back('{1'b0, {tag, idx, 2'b00}, 64'h0});
            exp_arr.push_back('{1'b1, idx, {2'b10, tag}, rd});
            lat = 1'b0;
            r_v[idx] = 1'b1; r_d[idx] = 1'b0; r_tag[idx] = tag; r_dat[idx] = rd;
         end
      end
      if (we) begin
         exp_arr.push_back('{1'b0, idx, {2'b11, tag}, wd});
         r_v[idx] = 1'b1; r_d[idx] = 1'b1; r_tag[idx] = tag; r_dat[idx] = wd;
      end
      exp_resp.push_back('{hit, rd, !we, lat, 32'(cyc), 32'(r_hc), 32'(r_mc)});
   endtask

   // L2 responder
   logic        hold_req, hold_resp, late_req;
   logic        hold_chk, hold_done, late_done, holding, first;
   logic        in_req, pending;
   int          delay, resp_wait;
   logic [63:0] pend_data;
   logic [96:0] snap;
   logic [63:0] l2_mem [logic [29:0]];

   initial begin
      l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_data = '0;
      in_req = 0; pending = 0; hold_chk = 0; hold_done = 0; late_done = 0;
      holding = 0; first = 0; delay = 0; resp_wait = 0; pend_data = '0; snap = '0;
      l2_mem[30'h101] = 64'hDEAD_BEEF_0000_0001;
      forever begin
         @(posedge clk); #2;
         l2_req_ready = 1'b0; l2_resp_valid = 1'b0; hold_chk = 1'b0;
         if (late_req && !late_done) begin
            l2_resp_valid = 1'b1;
            l2_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            late_done     = 1'b1;
         end
         if (rst) begin
            in_req = 0; pending = 0;
         end else if (pending) begin
            if (!hold_resp) begin
               if (resp_wait == 0) begin
                  l2_resp_valid = 1'b1;
                  l2_resp_data  = pend_data;
                  pending = 0;
               end else resp_wait--;
            end
         end else if (l2_req_valid) begin
            if (!in_req) begin
               in_req = 1; first = 1;
               if (hold_req && !hold_done) begin
                  delay = 5; hold_done = 1; holding = 1;
                  snap = {l2_req_we, l2_req_addr, l2_req_wdata};
               end else begin
                  delay = $urandom_range(0, 2); holding = 0;
               end
            end else first = 0;
            if (holding && !first) hold_chk = 1'b1;
            if (delay == 0) begin
               l2_req_ready = 1'b1;
               in_req = 0; pending = 1; resp_wait = $urandom_range(0, 3);
               if (l2_req_we) begin
                  l2_mem[l2_req_addr[31:2]] = l2_req_wdata;
                  pend_data = {$urandom, $urandom};
               end else begin
                  pend_data = l2_mem.exists(l2_req_addr[31:2]) ? l2_mem[l2_req_addr[31:2]]
                                                               : mem_init({l2_req_addr[31:2], 2'b00});
               end
            end else delay--;
         end
      end
   end

   // monitor: the only place that compares and counts
   logic zero_chk, ready_chk, drain_chk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: asserted with no expected entry (t=%0t)", name, $time);
   endtask

   initial begin
      resp_t e;
      l2_t   l;
      arr_t  a;
      forever begin
         @(negedge clk);
         if (cpu_resp_valid) begin
            if (exp_resp.size() == 0) unexpected("cpu_resp_valid");
            else begin
               e = exp_resp.pop_front();
               chk("resp_hit", 128'(cpu_resp_hit), 128'(e.hit));
               if (e.chk_rd) chk("resp_rdata", 128'(cpu_rdata), 128'(e.rdata));
               chk("hit_cnt", 128'(hit_cnt), 128'(e.hc));
               chk("miss_cnt", 128'(miss_cnt), 128'(e.mc));
               if (e.chk_lat) chk("resp_latency", 128'(cyc - int'(e.acc)), 128'(2));
            end
         end
         if (l2_req_valid && l2_req_ready) begin
            if (exp_l2.size() == 0) unexpected("l2_req");
            else begin
               l = exp_l2.pop_front();
               chk("l2_req_we", 128'(l2_req_we), 128'(l.we));
               chk("l2_req_addr", 128'(l2_req_addr), 128'(l.addr));
               if (l.we) chk("l2_req_wdata", 128'(l2_req_wdata), 128'(l.wdata));
            end
         end
         if (arr_cpu_we || arr_fill_we) begin
            chk("arr_we_exclusive", 128'(arr_cpu_we && arr_fill_we), 128'(0));
            if (exp_arr.size() == 0) unexpected("arr_write");
            else begin
               a = exp_arr.pop_front();
               chk("arr_write_kind", 128'({arr_fill_we, arr_cpu_we}), 128'({a.fill, !a.fill}));
               chk("arr_index", 128'(arr_addr[9:2]), 128'(a.idx));
               chk("arr_tag_upd", 128'(arr_tag_upd), 128'(a.tag_upd));
               chk("arr_write_data", 128'(a.fill ? arr_fill_data : arr_wdata), 128'(a.data));
            end
         end
         if (hold_chk)
            chk("wb_hold_stable", 128'({l2_req_valid, l2_req_we, l2_req_addr, l2_req_wdata, cpu_req_ready}),
                128'({1'b1, snap, 1'b0}));
         if (zero_chk)
            chk("outputs_zero", 128'(|{cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_resp_hit, arr_addr,
                arr_tag_upd, arr_fill_we, arr_fill_data, arr_cpu_we, arr_wdata, l2_req_valid,
                l2_req_we, l2_req_addr, l2_req_wdata, hit_cnt, miss_cnt}), 128'(0));
         if (ready_chk)
            chk("ready_after_rst", 128'({cpu_req_ready, cpu_resp_valid, arr_fill_we, arr_cpu_we, l2_req_valid}),
                128'(5'b10000));
         if (drain_chk)
            chk("queues_drained", 128'(exp_resp.size() + exp_l2.size() + exp_arr.size()), 128'(0));
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cpu_req_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cpu_req_ready) begin
         $display("FAIL req_ready_timeout: cpu_req_ready still 0 after %0d cycles", n);
         $fatal(1);
      end
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [63:0] wd);
      wait_ready();
      ref_req(we, addr, wd);
      cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [21:0] tag;
      int          n;
      rst = 1'b1; arr_clear = 1'b1;
      cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      hold_req = 1'b0; hold_resp = 1'b0; late_req = 1'b0;
      zero_chk = 1'b0; ready_chk = 1'b0; drain_chk = 1'b0;
      for (int i = 0; i < 256; i++) begin
         r_v[i] = 1'b0; r_d[i] = 1'b0; r_tag[i] = '0; r_dat[i] = '0;
      end
      r_hc = 0; r_mc = 0;
      ref_mem[30'h101] = 64'hDEAD_BEEF_0000_0001;

      repeat (3) @(posedge clk);
      #1 zero_chk = 1'b1;
      @(posedge clk); #1;
      zero_chk = 1'b0; rst = 1'b0; arr_clear = 1'b0;
      @(posedge clk); #1 ready_chk = 1'b1;
      @(posedge clk); #1 ready_chk = 1'b0;

      // cold miss, repeat hit, write hit, dirty eviction with a held L2 handshake
      do_req(1'b0, 32'h0000_0404, 64'h0);
      do_req(1'b0, 32'h0000_0404, 64'h0);
      do_req(1'b1, 32'h0000_0404, 64'h1111);
      hold_req = 1'b1;
      do_req(1'b0, 32'h0000_0804, 64'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0C08; cpu_wdata = 64'h5555;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      do_req(1'b1, 32'h0000_0C08, 64'h2222_0000_0000_2222);

      for (int k = 0; k < 250; k++) begin
         n   = $urandom_range(0, 3);
         tag = (n == 3) ? 22'h3F_FFFF : 22'(n);
         do_req(1'($urandom_range(0, 1)),
                {tag, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      // reset while a refill is outstanding; the late L2 response must be ignored
      wait_ready();
      hold_resp = 1'b1;
      exp_l2.push_back('{1'b0, 32'h0000_03FC, 64'h0});
      cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_03FC;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      n = 0;
      while (exp_l2.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_l2.size() != 0) begin
         $display("FAIL refill_req_timeout: no L2 refill handshake after %0d cycles", n);
         $fatal(1);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1 zero_chk = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; late_req = 1'b1;
      @(posedge clk); #1;
      zero_chk = 1'b0; ready_chk = 1'b1; hold_resp = 1'b0;
      r_hc = 0; r_mc = 0;
      @(posedge clk); #1 ready_chk = 1'b0;

      do_req(1'b0, 32'h0000_03FC, 64'h0);
      do_req(1'b0, 32'h0000_03FD, 64'h0);
      do_req(1'b1, 32'h0000_03FC, 64'h7777_8888_9999_AAAA);
      do_req(1'b0, 32'h0000_07FC, 64'h0);

      n = 0;
      while ((exp_resp.size() + exp_l2.size() + exp_arr.size()) != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      drain_chk = 1'b1;
      @(posedge clk); #1 drain_chk = 1'b0;
      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
